// File: rtl/arbiter2.sv
// arbiter2: two-requester, mutually exclusive grant arbiter.
// Moore FSM (IDLE / GNT0 / GNT1). The grants decode only from the state register.
// Simultaneous requests from IDLE go to master 0 by default.
// Compile-time option ARBITER_RR_EN alternates the winner of simultaneous
// requests, using a one-bit record of the most recent grant.
//
// Handshake: a master raises req_x and holds it for its whole transaction.
// gnt_x rises one edge after req_x is sampled high in IDLE, and stays high
// while req_x is held. It falls one edge after req_x is sampled low.
// An owner is never preempted.
// Hand-off always passes through IDLE, so both grants are low for at least one
// cycle between owners.
//
// state_q is the single source of FSM state; checkers can bind to it directly.
module arbiter2 (
    input  logic clock,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    // When both requests arrive together in IDLE, prefer_1 chooses master 1.
    logic prefer_1;

`ifdef ARBITER_RR_EN
    // last_q: 0 = master 0 got the most recent grant, 1 = master 1 did.
    // It resets to 1 so that master 0 wins the first tie.
    logic last_q;
    logic last_d;

    assign prefer_1 = ~last_q;

    // Record the owner whenever the FSM enters a grant state.
    always_comb begin
        last_d = last_q;
        if (state_d == GNT0) begin
            last_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_d = 1'b1;
        end
    end

    // Most-recent-grant register, with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: master 0 always wins a tie.
    assign prefer_1 = 1'b0;
`endif

    // Next-state logic. The unused code 2'b11 goes back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    state_d = prefer_1 ? GNT1 : GNT0;
                end else if (req_0) begin
                    state_d = GNT0;
                end else if (req_1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                state_d = req_0 ? GNT0 : IDLE;
            end
            GNT1: begin
                state_d = req_1 ? GNT1 : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset forces IDLE at once, without waiting for an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore outputs decode from the state register only.
    // At most one grant is high, and the unused code drives both low.
    assign gnt_0 = (state_q == GNT0);
    assign gnt_1 = (state_q == GNT1);

endmodule

// File: tb/tb_arbiter2.sv
// tb_arbiter2: directed self-checking bench for arbiter2.
// The tie-break expectations follow the ARBITER_RR_EN setting of the build.
module tb_arbiter2;

    logic clock;
    logic reset;
    logic req_0;
    logic req_1;
    logic gnt_0;
    logic gnt_1;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];

    arbiter2 dut (
        .clock (clock),
        .reset (reset),
        .req_0 (req_0),
        .req_1 (req_1),
        .gnt_0 (gnt_0),
        .gnt_1 (gnt_1)
    );

    // Clock and reset defaults.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold reset for two edges with requests low, then release between edges.
    task automatic do_reset();
        reset = 1'b0;
        req_0 = 1'b0;
        req_1 = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Check both grants against the expected {gnt_1, gnt_0} vector.
    task automatic check_gnt(input string name, input logic [1:0] exp);
        checks++;
        if ({gnt_1, gnt_0} !== exp) begin
            errors++;
            $display("FAIL %s: {gnt_1,gnt_0}=%b expected %b at %0t", name, {gnt_1, gnt_0}, exp, $time);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_0 = 1'b1;
        req_1 = 1'b1;
        #1;
        check_gnt("reset_hold_t0", 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            check_gnt("reset_hold", 2'b00);
        end
        reset = 1'b1;
        step();
        check_gnt("reset_release_first_edge", 2'b01);
        step();
        check_gnt("reset_pre_midgrant", 2'b01);
        reset = 1'b0;
        #1;
        check_gnt("reset_midgrant_async", 2'b00);
        step();
        check_gnt("reset_midgrant_held", 2'b00);
        req_0 = 1'b0;
        req_1 = 1'b0;
        reset = 1'b1;
        step();
        check_gnt("reset_after_release_idle", 2'b00);
    endtask

    task automatic test_single_grant();
        do_reset();
        step();
        req_0 = 1'b1;
        #1;
        check_gnt("single_before_edge", 2'b00);
        step();
        check_gnt("single_grant", 2'b01);
        req_0 = 1'b0;
        step();
        check_gnt("single_release", 2'b00);
        step();
        check_gnt("single_stays_idle", 2'b00);
    endtask

    task automatic test_priority();
        do_reset();
        req_0 = 1'b1;
        req_1 = 1'b1;
        step();
        check_gnt("prio_both_rise", 2'b01);
        req_0 = 1'b0;
        step();
        check_gnt("prio_handoff_gap", 2'b00);
        step();
        check_gnt("prio_handoff_gnt1", 2'b10);
        req_1 = 1'b0;
        step();
        check_gnt("prio_release_gnt1", 2'b00);
    endtask

    task automatic test_no_preemption();
        do_reset();
        req_1 = 1'b1;
        step();
        check_gnt("nopre_gnt1", 2'b10);
        req_0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_gnt("nopre_hold", 2'b10);
        end
        req_1 = 1'b0;
        step();
        check_gnt("nopre_gap", 2'b00);
        step();
        check_gnt("nopre_then_gnt0", 2'b01);
        req_0 = 1'b0;
        step();
        check_gnt("nopre_release", 2'b00);
    endtask

    // Repeated simultaneous requests, each held for two grant cycles.
    task automatic test_tie_sequence();
        logic [1:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef ARBITER_RR_EN
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp = 2'b01;
`endif
            req_0 = 1'b1;
            req_1 = 1'b1;
            step();
            check_gnt("tie_grant", exp);
            step();
            check_gnt("tie_hold", exp);
            req_0 = 1'b0;
            req_1 = 1'b0;
            step();
            check_gnt("tie_release", 2'b00);
        end
    endtask

    // Random requests, checked against an independent model of owner and tie record.
    task automatic test_random();
        int owner;
        logic exp_last;
        logic r0;
        logic r1;
        logic [1:0] exp;
        do_reset();
        owner = 0;
        exp_last = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            req_0 = r0;
            req_1 = r1;
            case (owner)
                0: begin
                    if (r0 && r1) begin
`ifdef ARBITER_RR_EN
                        owner = exp_last ? 1 : 2;
`else
                        owner = 1;
`endif
                    end else if (r0) begin
                        owner = 1;
                    end else if (r1) begin
                        owner = 2;
                    end
                end
                1: owner = r0 ? 1 : 0;
                default: owner = r1 ? 2 : 0;
            endcase
            if (owner == 1) exp_last = 1'b0;
            if (owner == 2) exp_last = 1'b1;
            exp_q.push_back({owner == 2, owner == 1});
            step();
            exp = exp_q.pop_front();
            check_gnt("random_grant", exp);
            checks++;
            if ((gnt_0 && gnt_1) || (gnt_0 && !r0) || (gnt_1 && !r1)) begin
                errors++;
                $display("FAIL random_mutex_req: gnt_0=%b gnt_1=%b req_0=%b req_1=%b", gnt_0, gnt_1, r0, r1);
            end
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        step();
        step();
        check_gnt("random_final_idle", 2'b00);
    endtask

    initial begin
        reset = 1'b0;
        req_0 = 1'b0;
        req_1 = 1'b0;
        test_reset();
        test_single_grant();
        test_priority();
        test_no_preemption();
        test_tie_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
